// File: rtl/instr_fetch.sv
// Multicycle instruction fetch: PC latch, memory read handshake,
// instruction register and MIPS field decode. Optional IF_TIMEOUT_EN.
module instr_fetch #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRead,
    input  logic              MemReady,
    input  logic [DATA_W-1:0] MemData,
    output logic              Busy,
    output logic              IRValid,
    output logic [DATA_W-1:0] Instr,
    output logic [5:0]        Opcode,
    output logic [4:0]        Rs,
    output logic [4:0]        Rt,
    output logic [4:0]        Rd,
    output logic [4:0]        Shamt,
    output logic [5:0]        Funct,
    output logic [15:0]       Imm16,
    output logic [25:0]       Jaddr,
    output logic              AddrErr,
    output logic              Timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] instr_q;
    logic              mem_read_q;
    logic              busy_q;
    logic              ir_valid_q;
    logic              addr_err_q;
    logic              aligned;

    assign aligned = (PC[1:0] == 2'b00);

`ifdef IF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] to_cnt_q;
    logic [CNT_W-1:0] to_cnt_d;
    logic             timeout_q;

    // Next value of the REQ wait counter.
    always_comb begin
        to_cnt_d = to_cnt_q + CNT_W'(1);
    end
`endif

    // Fetch FSM; every status output is a register so none of them
    // depends combinationally on an input.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            instr_q    <= '0;
            mem_read_q <= 1'b0;
            busy_q     <= 1'b0;
            ir_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
`ifdef IF_TIMEOUT_EN
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            ir_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
`ifdef IF_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (Start) begin
                        busy_q <= 1'b1;
                        if (aligned) begin
                            mem_addr_q <= PC;
                            mem_read_q <= 1'b1;
                            state_q    <= REQ;
`ifdef IF_TIMEOUT_EN
                            to_cnt_q   <= '0;
`endif
                        end else begin
                            addr_err_q <= 1'b1;
                            state_q    <= ERR;
                        end
                    end
                end
                REQ: begin
                    if (MemReady) begin
                        instr_q    <= MemData;
                        mem_read_q <= 1'b0;
                        ir_valid_q <= 1'b1;
                        state_q    <= DONE;
                    end
`ifdef IF_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        mem_read_q <= 1'b0;
                        timeout_q  <= 1'b1;
                        state_q    <= ERR;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                    end
`endif
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    mem_read_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign MemAddr = mem_addr_q;
    assign MemRead = mem_read_q;
    assign Busy    = busy_q;
    assign IRValid = ir_valid_q;
    assign AddrErr = addr_err_q;
    assign Instr   = instr_q;

`ifdef IF_TIMEOUT_EN
    assign Timeout = timeout_q;
`else
    assign Timeout = 1'b0;
`endif

    // Field slices follow the instruction register directly.
    assign Opcode = instr_q[31:26];
    assign Rs     = instr_q[25:21];
    assign Rt     = instr_q[20:16];
    assign Rd     = instr_q[15:11];
    assign Shamt  = instr_q[10:6];
    assign Funct  = instr_q[5:0];
    assign Imm16  = instr_q[15:0];
    assign Jaddr  = instr_q[25:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table, random fetches
// against a transaction-level model, and reset / back-to-back sequences.
module tb_instr_fetch;

    localparam int TO = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [31:0] PC;
    logic [31:0] MemAddr;
    logic        MemRead;
    logic        MemReady;
    logic [31:0] MemData;
    logic        Busy;
    logic        IRValid;
    logic [31:0] Instr;
    logic [5:0]  Opcode;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [4:0]  Shamt;
    logic [5:0]  Funct;
    logic [15:0] Imm16;
    logic [25:0] Jaddr;
    logic        AddrErr;
    logic        Timeout;

    int total = 0;
    int bad   = 0;

    // Transaction-level model of the architecturally visible registers.
    logic [31:0] m_instr;
    logic [31:0] m_addr;

    typedef enum int { K_V, K_E, K_T } kind_t;

    typedef struct {
        logic [31:0] pc;
        int          wt;
        logic [31:0] data;
        kind_t       kind;
        int          nrd;
    } vec_t;

    vec_t vecs[$];

    instr_fetch #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYC(TO)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .PC(PC),
        .MemAddr(MemAddr),
        .MemRead(MemRead),
        .MemReady(MemReady),
        .MemData(MemData),
        .Busy(Busy),
        .IRValid(IRValid),
        .Instr(Instr),
        .Opcode(Opcode),
        .Rs(Rs),
        .Rt(Rt),
        .Rd(Rd),
        .Shamt(Shamt),
        .Funct(Funct),
        .Imm16(Imm16),
        .Jaddr(Jaddr),
        .AddrErr(AddrErr),
        .Timeout(Timeout)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_memaddr"}, 64'(MemAddr), 64'(m_addr));
        chk({tag, "_instr"},   64'(Instr),   64'(m_instr));
        chk({tag, "_fields"},
            64'({Opcode, Rs, Rt, Rd, Shamt, Funct}),
            64'(m_instr));
        chk({tag, "_imm"},   64'(Imm16), 64'(m_instr & 32'hFFFF));
        chk({tag, "_jaddr"}, 64'(Jaddr), 64'(m_instr & 32'h03FF_FFFF));
    endtask

    function automatic kind_t classify(input logic [31:0] pc,
                                       input int wt);
        if (pc[1:0] != 2'b00) return K_E;
`ifdef IF_TIMEOUT_EN
        if (wt >= TO) return K_T;
`endif
        return K_V;
    endfunction

    // One fetch from IDLE: counts every strobe and MemRead cycle and
    // compares them with the model's expectations for this transaction.
    task automatic fetch(input string tag, input logic [31:0] pc,
                         input int wt, input logic [31:0] data,
                         input kind_t kind, input int exp_nrd);
        int nrd   = 0;
        int nval  = 0;
        int nerr  = 0;
        int nto   = 0;
        int nbusy = 0;
        int lat   = -1;
        int exp_lat;
        bit done  = 1'b0;
        Start    = 1'b1;
        PC       = pc;
        MemReady = 1'($urandom_range(0, 1));
        MemData  = $urandom;
        tick();
        Start = 1'b0;
        PC    = $urandom;
        for (int c = 0; c < 64 && !done; c++) begin
            if (!Busy) begin
                done = 1'b1;
            end else begin
                nbusy++;
                if (MemRead) nrd++;
                if (IRValid) begin nval++; lat = c; end
                if (AddrErr) begin nerr++; lat = c; end
                if (Timeout) begin nto++; lat = c; end
                Start = 1'($urandom_range(0, 1));
                if (MemRead && nrd == wt + 1) begin
                    MemReady = 1'b1;
                    MemData  = data;
                end else begin
                    MemReady = MemRead ? 1'b0 : 1'($urandom_range(0, 1));
                    MemData  = $urandom;
                end
                tick();
            end
        end
        Start    = 1'b0;
        MemReady = 1'b0;
        case (kind)
            K_V: begin exp_lat = wt + 1; m_instr = data; m_addr = pc; end
            K_E: begin exp_lat = 0; end
            default: begin exp_lat = TO; m_addr = pc; end
        endcase
        chk({tag, "_idle"},  64'(done), 64'(1));
        chk({tag, "_nrd"},   64'(nrd), 64'(exp_nrd));
        chk({tag, "_valid"}, 64'(nval), 64'(kind == K_V));
        chk({tag, "_aerr"},  64'(nerr), 64'(kind == K_E));
        chk({tag, "_tmo"},   64'(nto), 64'(kind == K_T));
        chk({tag, "_lat"},   64'(lat), 64'(exp_lat));
        chk({tag, "_busy"},  64'(nbusy), 64'(exp_lat + 1));
        chk_regs(tag);
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] rdat;
        int          rwt;
        kind_t       rk;
        int          nreq;
        int          nv;
        int          vpos[$];
        logic [31:0] vins[$];

        vecs.push_back('{32'h0000_0040, 0, 32'h8C22_0004, K_V, 1});
        vecs.push_back('{32'h0000_0040, 5, 32'h0043_0820, K_V, 6});
        vecs.push_back('{32'h0000_0042, 0, 32'hFFFF_FFFF, K_E, 0});
        vecs.push_back('{32'h0000_0003, 0, 32'h1234_5678, K_E, 0});
        vecs.push_back('{32'hFFFF_FFFC, 2, 32'hDEAD_BEEF, K_V, 3});
        vecs.push_back('{32'h0000_1000, 15, 32'h0800_0ABC, K_V, 16});
`ifdef IF_TIMEOUT_EN
        vecs.push_back('{32'h0000_2000, 16, 32'hAAAA_5555, K_T, TO});
        vecs.push_back('{32'h0000_3000, 40, 32'h5555_AAAA, K_T, TO});
`else
        vecs.push_back('{32'h0000_2000, 16, 32'hAAAA_5555, K_V, 17});
`endif

        Reset    = 1'b1;
        Start    = 1'b0;
        PC       = '0;
        MemReady = 1'b0;
        MemData  = '0;
        m_instr  = '0;
        m_addr   = '0;
        repeat (2) tick();
        chk("rst_status", 64'({MemRead, Busy, IRValid, AddrErr, Timeout}),
            64'(0));
        chk_regs("rst");
        Reset = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].wt,
                  vecs[i].data, vecs[i].kind, vecs[i].nrd);
            if (i == 0) begin
                chk("tp1_addr", 64'(MemAddr), 64'h40);
                chk("tp1_op",   64'(Opcode), 64'h23);
                chk("tp1_rsrt", 64'({Rs, Rt}), 64'({5'd1, 5'd2}));
                chk("tp1_imm",  64'(Imm16), 64'h4);
            end
            if (i == 1) begin
                chk("tp2_funct", 64'(Funct), 64'h20);
                chk("tp2_rd",    64'(Rd), 64'h1);
            end
            if (i == 2) begin
                chk("tp3_keep", 64'(Instr), 64'h0043_0820);
            end
        end

        for (int i = 0; i < 40; i++) begin
            rpc  = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            rwt  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18))
                                               : int'($urandom_range(0, 6));
            rdat = $urandom;
            rk   = classify(rpc, rwt);
            fetch($sformatf("rnd%0d", i), rpc, rwt, rdat, rk,
                  rk == K_E ? 0 : (rk == K_T ? TO : rwt + 1));
        end

        // Reset in the third REQ cycle discards the fetch.
        Start    = 1'b1;
        PC       = 32'h0000_0080;
        MemReady = 1'b0;
        tick();
        Start = 1'b0;
        tick();
        tick();
        chk("mid_req", 64'({MemRead, Busy}), 64'({1'b1, 1'b1}));
        #2;
        Reset = 1'b1;
        #1;
        m_instr = '0;
        m_addr  = '0;
        chk("mid_rst_status", 64'({MemRead, Busy, IRValid}), 64'(0));
        chk_regs("mid_rst");
        MemReady = 1'b1;
        MemData  = 32'hCAFE_F00D;
        tick();
        Reset = 1'b0;
        nv = 0;
        nreq = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (IRValid) nv++;
            if (MemRead) nreq++;
        end
        MemReady = 1'b0;
        chk("post_rst_valid", 64'(nv), 64'(0));
        chk("post_rst_rd",    64'(nreq), 64'(0));
        chk_regs("post_rst");

        // Start held high with zero-wait memory: one fetch per 3 cycles.
        Start    = 1'b1;
        PC       = 32'h0000_0100;
        MemReady = 1'b1;
        MemData  = 32'h1111_1111;
        tick();
        nreq = 0;
        for (int c = 0; c < 9; c++) begin
            if (IRValid) begin
                vpos.push_back(c);
                vins.push_back(Instr);
            end
            if (MemRead) nreq++;
            MemData = (nreq <= 1) ? 32'h1111_1111 : 32'h2222_2222;
            Start   = (c < 5);
            tick();
        end
        Start    = 1'b0;
        MemReady = 1'b0;
        chk("b2b_nreq", 64'(nreq), 64'(2));
        chk("b2b_nval", 64'(vpos.size()), 64'(2));
        if (vpos.size() == 2) begin
            chk("b2b_pos0", 64'(vpos[0]), 64'(1));
            chk("b2b_gap",  64'(vpos[1] - vpos[0]), 64'(3));
            chk("b2b_ins0", 64'(vins[0]), 64'h1111_1111);
            chk("b2b_ins1", 64'(vins[1]), 64'h2222_2222);
        end
        m_instr = 32'h2222_2222;
        m_addr  = 32'h0000_0100;
        chk_regs("b2b_end");
        chk("b2b_idle", 64'(Busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
